// File: rtl/ysyx_2022040010_div_seq_if.sv
// Request/response bundle between the EXU and the sequential divider.
// The master modport is the requester (EXU side) and the slave modport is the divider.
interface ysyx_2022040010_div_seq_if #(
  parameter int XLEN = 64
);
  logic            start_i;
  logic            annul_i;
  logic            signed_div_i;
  logic            div_32;
  logic [1:0]      div_res_sel;
  logic [XLEN-1:0] opdata1_i;
  logic [XLEN-1:0] opdata2_i;
  logic            busy_o;
  logic            ready_o;
  logic [XLEN-1:0] div_res_o;

  modport master (
    output start_i, annul_i, signed_div_i, div_32, div_res_sel, opdata1_i, opdata2_i,
    input  busy_o, ready_o, div_res_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, div_32, div_res_sel, opdata1_i, opdata2_i,
    output busy_o, ready_o, div_res_o
  );
endinterface

// File: rtl/ysyx_2022040010_div_seq.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU and W forms) with start/ready handshake.
// Define YSYX_DIV_EARLY_OUT_EN to skip the dividend's leading-zero iterations.
module ysyx_2022040010_div_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  ysyx_2022040010_div_seq_if.slave       div_if
);
  localparam int HALF = XLEN / 2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] dvd_reg, dvs_reg, rem_reg, res_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic            word_reg, sel_q_reg, q_neg_reg, r_neg_reg, ready_reg;

  logic [XLEN-1:0] ext_a, ext_b, ext_min, abs_a, abs_b, aligned_a, init_dvd;
  logic [CNT_W-1:0] n_eff, init_cnt;
  logic            s1, s2, div_zero, ovf, accept;
  logic [XLEN:0]   wide;
  logic            take;
  logic [XLEN-1:0] q_fix, r_fix, pick, final_res;

  // Operand conditioning: extend to XLEN, then take magnitudes of the N-bit values.
  always_comb begin
    if (div_if.div_32) begin
      ext_a = div_if.signed_div_i ? {{HALF{div_if.opdata1_i[HALF-1]}}, div_if.opdata1_i[HALF-1:0]}
                                  : {{HALF{1'b0}}, div_if.opdata1_i[HALF-1:0]};
      ext_b = div_if.signed_div_i ? {{HALF{div_if.opdata2_i[HALF-1]}}, div_if.opdata2_i[HALF-1:0]}
                                  : {{HALF{1'b0}}, div_if.opdata2_i[HALF-1:0]};
      ext_min = {{HALF{1'b1}}, 1'b1, {(HALF-1){1'b0}}};
      n_eff   = CNT_W'(HALF);
    end else begin
      ext_a   = div_if.opdata1_i;
      ext_b   = div_if.opdata2_i;
      ext_min = {1'b1, {(XLEN-1){1'b0}}};
      n_eff   = CNT_W'(XLEN);
    end
    s1        = div_if.signed_div_i & ext_a[XLEN-1];
    s2        = div_if.signed_div_i & ext_b[XLEN-1];
    abs_a     = s1 ? (XLEN'(0) - ext_a) : ext_a;
    abs_b     = s2 ? (XLEN'(0) - ext_b) : ext_b;
    // Dividend bits must enter the shift register from its top, so word operands are left-aligned.
    aligned_a = div_if.div_32 ? {abs_a[HALF-1:0], {HALF{1'b0}}} : abs_a;
    div_zero  = (ext_b == '0);
    ovf       = div_if.signed_div_i && (ext_a == ext_min) && (ext_b == '1);
  end

`ifdef YSYX_DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] clz, skip;
  logic             found;

  always_comb begin
    clz   = '0;
    found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!found) begin
        if (aligned_a[i]) found = 1'b1;
        else              clz   = clz + CNT_W'(1);
      end
    end
    // A zero dividend still needs one iteration so the counter never starts at 0.
    skip = (clz >= n_eff) ? (n_eff - CNT_W'(1)) : clz;
  end

  assign init_dvd = aligned_a << skip;
  assign init_cnt = n_eff - skip;
`else
  assign init_dvd = aligned_a;
  assign init_cnt = n_eff;
`endif

  // A request still held high during the ready_o cycle belongs to the op just finished.
  assign accept = (state_reg == S_IDLE) && div_if.start_i && !div_if.annul_i && !ready_reg;

  assign wide = {rem_reg, dvd_reg[XLEN-1]};
  assign take = (wide >= {1'b0, dvs_reg});

  always_comb begin
    q_fix     = q_neg_reg ? (XLEN'(0) - dvd_reg) : dvd_reg;
    r_fix     = r_neg_reg ? (XLEN'(0) - rem_reg) : rem_reg;
    pick      = sel_q_reg ? q_fix : r_fix;
    final_res = word_reg ? {{HALF{pick[HALF-1]}}, pick[HALF-1:0]} : pick;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = (div_zero || ovf) ? S_DONE : S_CALC;
      S_CALC: begin
        if (div_if.annul_i)              state_next = S_IDLE;
        else if (cnt_reg == CNT_W'(1))   state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    div_if.busy_o    = (state_reg != S_IDLE);
    div_if.ready_o   = ready_reg;
    div_if.div_res_o = ready_reg ? res_reg : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      res_reg   <= '0;
      cnt_reg   <= '0;
      word_reg  <= 1'b0;
      sel_q_reg <= 1'b0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      res_reg   <= '0;
      case (state_reg)
        S_IDLE: if (accept) begin
          word_reg  <= div_if.div_32;
          sel_q_reg <= div_if.div_res_sel[1] | ~div_if.div_res_sel[0];
          dvs_reg   <= abs_b;
          cnt_reg   <= init_cnt;
          // Special results are preloaded raw, with sign correction disabled.
          if (div_zero) begin
            dvd_reg   <= '1;
            rem_reg   <= ext_a;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
          end else if (ovf) begin
            dvd_reg   <= ext_a;
            rem_reg   <= '0;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
          end else begin
            dvd_reg   <= init_dvd;
            rem_reg   <= '0;
            q_neg_reg <= s1 ^ s2;
            r_neg_reg <= s1;
          end
        end
        S_CALC: begin
          dvd_reg <= {dvd_reg[XLEN-2:0], take};
          rem_reg <= take ? XLEN'(wide - {1'b0, dvs_reg}) : wide[XLEN-1:0];
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
        S_DONE: if (!div_if.annul_i) begin
          ready_reg <= 1'b1;
          res_reg   <= final_res;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_2022040010_div_seq.sv
// Self-checking bench for ysyx_2022040010_div_seq: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_ysyx_2022040010_div_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_2022040010_div_seq_if #(.XLEN(64)) dif ();

  ysyx_2022040010_div_seq #(.XLEN(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V divide semantics using plain language arithmetic.
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic sg, input logic w,
                                          input logic [1:0] sel, output bit sp);
    logic [31:0] a32, b32, q32, r32, p32;
    logic [63:0] q64, r64;
    sp  = 1'b0;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32; sp = 1'b1;
      end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0; sp = 1'b1;
      end else if (sg) begin
        q32 = 32'($signed(a32) / $signed(b32));
        r32 = 32'($signed(a32) % $signed(b32));
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      p32 = sel[1] ? q32 : r32;
      return {{32{p32[31]}}, p32};
    end
    if (b == 64'd0) begin
      q64 = '1; r64 = a; sp = 1'b1;
    end else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q64 = a; r64 = 64'd0; sp = 1'b1;
    end else if (sg) begin
      q64 = 64'($signed(a) / $signed(b));
      r64 = 64'($signed(a) % $signed(b));
    end else begin
      q64 = a / b;
      r64 = a % b;
    end
    return sel[1] ? q64 : r64;
  endfunction

  // One request held until ready_o; lat counts cycles with the accepting cycle as 0.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic sg, input logic w, input logic [1:0] sel,
                       input logic [63:0] exp_res, input int exp_lat, input bit restart,
                       output int lat);
    bit got;
    @(posedge clk); #1;
    chk({tag, "/idle_ready"}, {63'd0, dif.ready_o}, 64'd0);
    chk({tag, "/idle_res"}, dif.div_res_o, 64'd0);
    dif.start_i      = 1'b1;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.signed_div_i = sg;
    dif.div_32       = w;
    dif.div_res_sel  = sel;
    @(posedge clk); #1;
    chk({tag, "/busy"}, {63'd0, dif.busy_o}, 64'd1);
    dif.opdata1_i = {$urandom, $urandom};
    dif.opdata2_i = {$urandom, $urandom};
    lat = 1;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (dif.ready_o) got = 1'b1;
      else if (restart && lat == 6) begin
        dif.start_i     = 1'b0;
        dif.opdata2_i   = 64'd3;
        dif.div_res_sel = 2'b01;
      end else if (restart && lat == 7) dif.start_i = 1'b1;
    end
    chk({tag, "/ready_seen"}, {63'd0, got}, 64'd1);
    chk({tag, "/result"}, dif.div_res_o, exp_res);
`ifdef YSYX_DIV_EARLY_OUT_EN
    chk({tag, "/latency_bound"}, {63'd0, (lat <= exp_lat)}, 64'd1);
`else
    chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
`endif
    dif.start_i = 1'b0;
    $display("op %s a=0x%0h b=0x%0h sg=%0d w=%0d sel=%0b res=0x%0h exp=0x%0h lat=%0d",
             tag, a, b, sg, w, sel, dif.div_res_o, exp_res, lat);
  endtask

  task automatic watch_no_ready(input string tag, input int n);
    bit seen = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (dif.ready_o) seen = 1'b1;
    end
    chk(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    int         lat;
    bit         sp;
    logic [63:0] a, b, e;
    logic        sg, w;
    logic [1:0]  sel;

    dif.start_i = 1'b0; dif.annul_i = 1'b0; dif.signed_div_i = 1'b0; dif.div_32 = 1'b0;
    dif.div_res_sel = 2'b10; dif.opdata1_i = '0; dif.opdata2_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/busy", {63'd0, dif.busy_o}, 64'd0);
    chk("reset/ready", {63'd0, dif.ready_o}, 64'd0);
    chk("reset/res", dif.div_res_o, 64'd0);
    rst = 1'b0;

    do_op("divu_q", 64'd100, 64'd7, 1'b0, 1'b0, 2'b10, 64'd14, 66, 1'b0, lat);
    do_op("remu_r", 64'd100, 64'd7, 1'b0, 1'b0, 2'b01, 64'd2, 66, 1'b0, lat);
    do_op("div_neg", -64'sd7, 64'd2, 1'b1, 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b0, lat);
    do_op("rem_neg", -64'sd7, 64'd2, 1'b1, 1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b0, lat);
    do_op("div0_q", 64'h1234, 64'd0, 1'b0, 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0, lat);
    do_op("div0_r", 64'h1234, 64'd0, 1'b0, 1'b0, 2'b01, 64'h1234, 2, 1'b0, lat);
    do_op("ovf_q", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 2'b10, 64'h8000_0000_0000_0000, 2, 1'b0, lat);
    do_op("ovf_r", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 2'b01, 64'd0, 2, 1'b0, lat);
    do_op("divw_ovf", 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 2'b10, 64'hFFFF_FFFF_8000_0000, 2, 1'b0, lat);
    do_op("divuw", 64'hFFFF_FFFE, 64'd1, 1'b0, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 34, 1'b0, lat);
    do_op("both_sel", 64'd100, 64'd7, 1'b0, 1'b0, 2'b11, 64'd14, 66, 1'b0, lat);
    do_op("restart_ign", 64'd100, 64'd7, 1'b0, 1'b0, 2'b10, 64'd14, 66, 1'b1, lat);
    do_op("eo_5_1", 64'd5, 64'd1, 1'b0, 1'b0, 2'b10, 64'd5, 66, 1'b0, lat);
`ifdef YSYX_DIV_EARLY_OUT_EN
    chk("eo_5_1/faster", {63'd0, (lat < 66)}, 64'd1);
`endif

    // Annul mid-calculation: no result, busy drops on the next edge.
    @(posedge clk); #1;
    dif.start_i = 1'b1; dif.opdata1_i = 64'd100; dif.opdata2_i = 64'd7;
    dif.signed_div_i = 1'b0; dif.div_32 = 1'b0; dif.div_res_sel = 2'b10;
    repeat (10) @(posedge clk);
    #1;
    dif.annul_i = 1'b1; dif.start_i = 1'b0;
    @(posedge clk); #1;
    chk("annul/busy", {63'd0, dif.busy_o}, 64'd0);
    chk("annul/ready", {63'd0, dif.ready_o}, 64'd0);
    dif.annul_i = 1'b0;
    watch_no_ready("annul/no_ready", 80);

    // Annul in IDLE beats a simultaneous start.
    @(posedge clk); #1;
    dif.start_i = 1'b1; dif.annul_i = 1'b1;
    @(posedge clk); #1;
    chk("annul_idle/busy", {63'd0, dif.busy_o}, 64'd0);
    dif.start_i = 1'b0; dif.annul_i = 1'b0;
    do_op("after_annul", 64'd9, 64'd3, 1'b0, 1'b0, 2'b10, 64'd3, 66, 1'b0, lat);

    // Reset mid-calculation.
    @(posedge clk); #1;
    dif.start_i = 1'b1; dif.opdata1_i = 64'd100; dif.opdata2_i = 64'd7;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; dif.start_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid/busy", {63'd0, dif.busy_o}, 64'd0);
    chk("rst_mid/ready", {63'd0, dif.ready_o}, 64'd0);
    chk("rst_mid/res", dif.div_res_o, 64'd0);
    rst = 1'b0;
    watch_no_ready("rst_mid/no_ready", 80);

    for (int i = 0; i < 40; i++) begin
      sg  = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(1, 3));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 20)) ^ (sg ? '1 : 64'd0);
        2: begin a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
        3: a = 64'($urandom_range(0, 1000));
        default: ;
      endcase
      e = ref_div(a, b, sg, w, sel, sp);
      do_op($sformatf("rnd%0d", i), a, b, sg, w, sel, e, sp ? 2 : (w ? 34 : 66), 1'b0, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
